// File: rtl/dac_dual_spi_tx.sv
`default_nettype none
// ============================================================================
// dac_dual_spi_tx : two-channel SPI serializer for an MCP4822-class dual DAC
// Revision 1.0
// ============================================================================
module dac_dual_spi_tx #(
  parameter int   N       = 16,
  parameter int   CLK_DIV = 4,
  parameter logic GAIN_1X = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [N-1:0] i_sample_a,
  input  logic [N-1:0] i_sample_b,
  input  logic [1:0]   i_ch_en,
  output logic         o_cs_n,
  output logic         o_sck,
  output logic         o_sdi,
  output logic         o_ldac_n,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_overrun
);

  localparam int            CW         = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [CW-1:0] c_CNT_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] c_CNT_HALF = CW'(CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT_A = 3'd1,
    S_GAP     = 3'd2,
    S_SHIFT_B = 3'd3,
    S_LDAC    = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [15:0]   r_frame_a;
  logic [15:0]   r_frame_b;
  logic          r_busy;

  logic w_accept;
  logic w_cnt_last;
  logic w_shifting;
  logic w_cs_n_nxt;
  logic w_sck_nxt;
  logic w_sdi_nxt;
  logic w_ldac_n_nxt;
  logic w_busy_nxt;
  logic w_done_nxt;
  logic w_overrun_nxt;

  // Signed to offset-binary: flip the sign bit, keep the top 11 magnitude bits.
  function automatic logic [11:0] to_code(input logic [N-1:0] s);
    return {~s[N-1], s[N-2 -: 11]};
  endfunction

  generate
    if (N > 12) begin : g_unused_lsbs
      logic w_unused_lsbs;
      assign w_unused_lsbs = ^{i_sample_a[N-13:0], i_sample_b[N-13:0]};
    end
  endgenerate

  // r_busy still high in the first IDLE cycle, so a start there is an overrun.
  assign w_accept   = i_start && (r_state == S_IDLE) && !r_busy;
  assign w_cnt_last = (r_cnt == c_CNT_LAST);
  assign w_shifting = (r_state == S_SHIFT_A) || (r_state == S_SHIFT_B);

  always_comb begin
    w_state_nxt   = r_state;
    w_cs_n_nxt    = 1'b1;
    w_sck_nxt     = 1'b0;
    w_sdi_nxt     = 1'b0;
    w_ldac_n_nxt  = 1'b1;
    w_busy_nxt    = (r_state != S_IDLE);
    w_done_nxt    = (r_state == S_IDLE) && r_busy;
    w_overrun_nxt = i_start && !w_accept;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_SHIFT_A;
      end
      S_SHIFT_A: begin
        w_cs_n_nxt = 1'b0;
        w_sck_nxt  = (r_cnt >= c_CNT_HALF);
        w_sdi_nxt  = r_frame_a[~r_bit];
        if (w_cnt_last && (r_bit == 4'd15)) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (w_cnt_last) w_state_nxt = S_SHIFT_B;
      end
      S_SHIFT_B: begin
        w_cs_n_nxt = 1'b0;
        w_sck_nxt  = (r_cnt >= c_CNT_HALF);
        w_sdi_nxt  = r_frame_b[~r_bit];
        if (w_cnt_last && (r_bit == 4'd15)) w_state_nxt = S_LDAC;
      end
      S_LDAC: begin
        w_ldac_n_nxt = 1'b0;
        if (w_cnt_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_bit <= 4'd0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= '0;
      r_bit <= 4'd0;
    end else if (w_cnt_last) begin
      r_cnt <= '0;
      if (w_shifting) r_bit <= r_bit + 4'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_a <= 16'd0;
      r_frame_b <= 16'd0;
    end else if (w_accept) begin
      r_frame_a <= {1'b0, 1'b0, GAIN_1X, i_ch_en[0], to_code(i_sample_a)};
      r_frame_b <= {1'b1, 1'b0, GAIN_1X, i_ch_en[1], to_code(i_sample_b)};
    end
  end

  // Pins are registered copies of the state decode, one cycle behind r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_cs_n    <= 1'b1;
      o_sck     <= 1'b0;
      o_sdi     <= 1'b0;
      o_ldac_n  <= 1'b1;
      r_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_cs_n    <= w_cs_n_nxt;
      o_sck     <= w_sck_nxt;
      o_sdi     <= w_sdi_nxt;
      o_ldac_n  <= w_ldac_n_nxt;
      r_busy    <= w_busy_nxt;
      o_done    <= w_done_nxt;
      o_overrun <= w_overrun_nxt;
    end
  end

  assign o_busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dac_dual_spi_tx.sv
`default_nettype none
// ============================================================================
// tb_dac_dual_spi_tx : directed bench for dac_dual_spi_tx at CLK_DIV=4 and 1
// Revision 1.0
// ============================================================================
module tb_dac_dual_spi_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic [15:0] sa = 16'd0;
  logic [15:0] sb = 16'd0;
  logic [1:0]  en = 2'd0;

  logic cs4, sck4, sdi4, ldac4, busy4, done4, ov4;
  logic cs1, sck1, sdi1, ldac1, busy1, done1, ov1;
  logic w_cs, w_sck, w_sdi, w_ldac, w_busy, w_done, w_ov;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dac_dual_spi_tx #(.N(16), .CLK_DIV(4), .GAIN_1X(1'b1)) u_dut4 (
    .clk(clk), .rst(rst), .i_start(start & ~sel),
    .i_sample_a(sa), .i_sample_b(sb), .i_ch_en(en),
    .o_cs_n(cs4), .o_sck(sck4), .o_sdi(sdi4), .o_ldac_n(ldac4),
    .o_busy(busy4), .o_done(done4), .o_overrun(ov4)
  );

  dac_dual_spi_tx #(.N(16), .CLK_DIV(1), .GAIN_1X(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(start & sel),
    .i_sample_a(sa), .i_sample_b(sb), .i_ch_en(en),
    .o_cs_n(cs1), .o_sck(sck1), .o_sdi(sdi1), .o_ldac_n(ldac1),
    .o_busy(busy1), .o_done(done1), .o_overrun(ov1)
  );

  assign w_cs   = sel ? cs1   : cs4;
  assign w_sck  = sel ? sck1  : sck4;
  assign w_sdi  = sel ? sdi1  : sdi4;
  assign w_ldac = sel ? ldac1 : ldac4;
  assign w_busy = sel ? busy1 : busy4;
  assign w_done = sel ? done1 : done4;
  assign w_ov   = sel ? ov1   : ov4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, {18'd0, cs4, sck4, sdi4, ldac4, busy4, done4, ov4,
                     cs1, sck1, sdi1, ldac1, busy1, done1, ov1},
        {18'd0, 7'b1001000, 7'b1001000});
  endtask

  task automatic kick(input logic [15:0] a, input logic [15:0] b, input logic [1:0] e);
    sa = a; sb = b; en = e; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered just after the edge that sampled start (edge 0).
  task automatic observe(input int d, input logic [15:0] ea, input logic [15:0] eb,
                         input int ov, input bit mut, input bit chain,
                         input logic [15:0] na, input logic [15:0] nb, input logic [1:0] ne);
    logic [31:0] rx;
    int nrise, unstable, first_low, cs_rise, ldac_fall, ldac_low, done_k, nov, ov_k;
    logic p_sck, p_sdi, p_cs, busy_done, busy1st;
    rx = 32'd0; nrise = 0; unstable = 0; first_low = 0; cs_rise = 0;
    ldac_fall = 0; ldac_low = 0; done_k = 0; nov = 0; ov_k = 0;
    busy_done = 1'bx; busy1st = 1'bx;
    p_sck = w_sck; p_sdi = w_sdi; p_cs = w_cs;
    for (int k = 1; k <= 70 * d + 10 && done_k == 0; k++) begin
      if (k == ov) start = 1'b1;
      if (mut && k == 3) begin sa = ~sa; sb = sb + 16'h1111; en = ~en; end
      tick();
      start = 1'b0;
      if (k == 1) busy1st = w_busy;
      if (w_sck && !p_sck) begin
        rx = {rx[30:0], w_sdi};
        nrise++;
        if (w_sdi !== p_sdi || w_cs !== 1'b0) unstable++;
      end
      if (!w_cs && first_low == 0) first_low = k;
      if (w_cs && !p_cs && cs_rise == 0) cs_rise = k;
      if (!w_ldac) begin ldac_low++; if (ldac_fall == 0) ldac_fall = k; end
      if (w_ov) begin nov++; ov_k = k; end
      if (w_done) begin done_k = k; busy_done = w_busy; end
      p_sck = w_sck; p_sdi = w_sdi; p_cs = w_cs;
    end
    chk("frame_a", {16'd0, rx[31:16]}, {16'd0, ea});
    chk("frame_b", {16'd0, rx[15:0]}, {16'd0, eb});
    chk("sck_rises", nrise, 32);
    chk("sdi_unstable", unstable, 0);
    chk("busy_edge1", {31'd0, busy1st}, 1);
    chk("cs_fall_edge", first_low, 1);
    chk("cs_rise_edge", cs_rise, 1 + 32 * d);
    chk("ldac_fall_edge", ldac_fall, 1 + 66 * d);
    chk("ldac_low_cycles", ldac_low, 2 * d);
    chk("done_edge", done_k, 1 + 68 * d);
    chk("busy_at_done", {31'd0, busy_done}, 0);
    chk("overrun_count", nov, (ov > 0) ? 1 : 0);
    chk("overrun_edge", ov_k, ov);
    if (chain) begin sa = na; sb = nb; en = ne; start = 1'b1; end
    tick();
    start = 1'b0;
    chk("done_one_cycle", {31'd0, w_done}, 0);
  endtask

  task automatic quiet(input int n, input string tag);
    int lo_ldac, lo_cs;
    lo_ldac = 0; lo_cs = 0;
    repeat (n) begin
      tick();
      if (!w_ldac) lo_ldac++;
      if (!w_cs) lo_cs++;
    end
    chk({tag, "_ldac_low"}, lo_ldac, 0);
    chk({tag, "_cs_low"}, lo_cs, 0);
  endtask

  initial begin
    tick();
    chk_reset("reset_init");
    tick();
    rst = 1'b0;
    tick();

    kick(16'h0000, 16'h7FFF, 2'b11);
    observe(4, 16'h3800, 16'hBFFF, 0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);

    kick(16'h8000, 16'h1234, 2'b01);
    observe(4, 16'h3000, 16'hA923, 50, 1'b0, 1'b1, 16'hFFFF, 16'h0010, 2'b10);
    observe(4, 16'h27FF, 16'hB801, 0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);

    // Abort during bit 7 of frame A
    kick(16'h0000, 16'h7FFF, 2'b11);
    repeat (60) tick();
    chk("abort_a_cs_before", {31'd0, w_cs}, 0);
    rst = 1'b1;
    #1;
    chk_reset("abort_a_reset");
    tick();
    rst = 1'b0;
    quiet(300, "abort_a");

    kick(16'h0123, 16'hFEDC, 2'b11);
    observe(4, 16'h3812, 16'hB7ED, 0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);

    tick();
    rst = 1'b1;
    #1;
    chk_reset("reset_idle");
    tick();
    rst = 1'b0;
    tick();

    // Abort during frame B
    kick(16'h0000, 16'h7FFF, 2'b11);
    repeat (150) tick();
    chk("abort_b_cs_before", {31'd0, w_cs}, 0);
    rst = 1'b1;
    #1;
    chk_reset("abort_b_reset");
    tick();
    rst = 1'b0;
    quiet(300, "abort_b");

    sel = 1'b1;
    tick();
    kick(16'h4000, 16'hC000, 2'b11);
    observe(1, 16'h3C00, 16'hB400, 0, 1'b1, 1'b0, 16'h0, 16'h0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dac_dual_spi_tx.md
# dac_dual_spi_tx

Dual-channel DAC serializer: the consumer end of the waveform generators' sample outputs. On each sample strobe it latches the channel A and B samples and converts them from signed two's-complement to 12-bit offset-binary DAC codes. It then shifts two 16-bit SPI frames (mode 0) to an MCP4822-class dual DAC and pulses LDAC so both outputs update together. It sits between the generator/mux stage and the board's DAC pins.

## Interface
- N, 16, sample width; must be ≥ 12
- CLK_DIV, 4, clk cycles per SCK half-period; must be ≥ 1
- GAIN_1X, 1, value driven on frame bit 13 (GA): 1 selects 1x, 0 selects 2x

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  sample strobe, sampled each clk
- sample_a  in  N  signed channel A sample
- sample_b  in  N  signed channel B sample
- ch_en  in  2  bit0 enables A, bit1 enables B (drives SHDN bit)
- cs_n  out  1  DAC chip select, active low
- sck  out  1  SPI clock, idles low
- sdi  out  1  SPI data, MSB first
- ldac_n  out  1  DAC latch strobe, active low
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- overrun  out  1  one-cycle pulse when start is dropped

## Operation
- States: IDLE, SHIFT_A, GAP, SHIFT_B, LDAC, then back to IDLE.
- IDLE with start=1: latch sample_a, sample_b and ch_en, then enter SHIFT_A. Inputs are ignored after the latch.
- Code conversion: code = {~s[N-1], s[N-2:N-12]}.
  - 0 → 0x800.
  - max positive → 0xFFF.
  - min negative → 0x000.
- Frame layout:
  - bit15 = channel (0 = A, 1 = B)
  - bit14 = 0
  - bit13 = GAIN_1X
  - bit12 = ch_en bit for that channel (0 shuts that DAC output down)
  - bits 11:0 = code
- The frame is still sent when its channel is disabled.
- SHIFT_x: 16 bits MSB first. Each bit is sck low for CLK_DIV cycles, then sck high for CLK_DIV cycles. sdi changes only while sck is low and is stable across the sck rising edge.
- After the 16th bit's high half, sck returns low and cs_n goes high together, then the next state starts.
- GAP: cs_n high for 2·CLK_DIV cycles, then SHIFT_B.
- LDAC: cs_n high, ldac_n low for 2·CLK_DIV cycles, then IDLE.
- done pulses in the first IDLE cycle.
- start while busy=1: ignored and overrun pulses for one cycle. The transfer in progress is unaffected.
- start in the done cycle is accepted, because busy is already 0.

## Timing
- Reset values, applied immediately while rst is high: cs_n=1, sck=0, sdi=0, ldac_n=1, busy=0, done=0, overrun=0, state IDLE.
- rst asserted mid-transfer aborts it. cs_n goes high at once, the partial frame is discarded and no LDAC pulse is issued.
- Let start be sampled at edge 0 (D = CLK_DIV):
  - busy=1, cs_n=0 and sdi = A bit15, all from edge 1.
  - first sck rise at edge 1+D.
  - cs_n rises at edge 1+32D.
  - cs_n falls for frame B at edge 1+34D.
  - cs_n rises after frame B at edge 1+66D, and ldac_n falls at the same edge.
  - ldac_n rises at edge 1+68D; busy=0 and done=1 at that same edge.
- Total latency from start to done is 68D+1 cycles, i.e. 273 cycles at D=4.
- All outputs are registered (no combinational path from inputs to outputs).
- Counters:
  - half-period counter, width ⌈log2(2D)⌉ minimum
  - 4-bit bit counter, wraps 15→0 at the end of a frame

## Test plan
- Reset: assert rst mid-idle and mid-SHIFT_B → all outputs take their reset values in the same cycle; busy, done and overrun are 0.
- D=4, sample_a=0x0000, sample_b=0x7FFF, ch_en=2'b11, start pulse → frame A 0x3800, frame B 0xBFFF, MSB first; ldac_n low for 8 cycles; done at cycle 273.
- sample_a=0x8000, sample_b=0x1234, ch_en=2'b01 → frame A 0x3000, frame B 0xA923 (SHDN=0).
- Overrun: start again at cycle 50 → overrun high for 1 cycle; frames and done cycle unchanged. Then start in the done cycle → new transfer begins, cs_n low at the next edge.
- Reset abort: rst during bit 7 of frame A → cs_n high immediately and no ldac_n pulse; a subsequent start gives a complete, correct sequence.
- CLK_DIV=1: sck period of 2 cycles, sdi stable at every sck rise, done at cycle 69; samples changed mid-transfer do not alter the frames.
